// File: rtl/vga_timing.sv
//------------------------------------------------------------------------------
// vga_timing : free-running 800x600@60 raster counter, sync and blank generator
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN (adds the frame_cnt output)
// Revision   : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module vga_timing #(
  parameter int H_VISIBLE    = 800,
  parameter int H_SYNC_START = 840,
  parameter int H_SYNC_END   = 968,
  parameter int H_TOTAL      = 1056,
  parameter int V_VISIBLE    = 600,
  parameter int V_SYNC_START = 601,
  parameter int V_SYNC_END   = 605,
  parameter int V_TOTAL      = 628
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [`VGA_BUS_SIZE-1:0] vga_out,
  output logic                     frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]              frame_cnt
`endif
);

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SS   = 11'(H_SYNC_START);
  localparam logic [10:0] H_SE   = 11'(H_SYNC_END);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SS   = 11'(V_SYNC_START);
  localparam logic [10:0] V_SE   = 11'(V_SYNC_END);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap;
  logic        frame_wrap;

  // Flags are computed from the next counter values so that, once registered,
  // they line up with the counters they describe on the bus.
  always_comb begin
    h_wrap     = (hcount_q == H_LAST);
    frame_wrap = h_wrap && (vcount_q == V_LAST);
    hcount_d   = hcount_q + 11'd1;
    vcount_d   = vcount_q;
    if (h_wrap) begin
      hcount_d = 11'd0;
      vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
    end
    hblnk_d       = (hcount_d >= H_VIS);
    hsync_d       = (hcount_d >= H_SS) && (hcount_d < H_SE);
    vblnk_d       = (vcount_d >= V_VIS);
    vsync_d       = (vcount_d >= V_SS) && (vcount_d < V_SE);
    frame_start_d = (hcount_d == 11'd0) && (vcount_d == 11'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      hblnk_q       <= hblnk_d;
      vsync_q       <= vsync_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
`endif

  // RGB starts black; the overlay stages downstream paint on top of it.
  assign vga_out = {vcount_q, vsync_q, vblnk_q, hcount_q, hsync_q, hblnk_q, 12'h000};
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
//------------------------------------------------------------------------------
// tb_vga_timing : boundary vectors, async-reset sequences and randomized resets
// for vga_timing, checked cycle by cycle against a time-based raster model.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing;

  // Reduced geometry for the second instance so whole frames fit in a short run.
  localparam int SHV = 16, SHSS = 18, SHSE = 22, SHT = 26;
  localparam int SVV = 10, SVSS = 11, SVSE = 13, SVT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [37:0] bus_d, bus_s;
  logic        fs_d, fs_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_d, fc_s;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  vga_timing dut_d (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (bus_d),
    .frame_start (fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (fc_d)
`endif
  );

  vga_timing #(
    .H_VISIBLE(SHV), .H_SYNC_START(SHSS), .H_SYNC_END(SHSE), .H_TOTAL(SHT),
    .V_VISIBLE(SVV), .V_SYNC_START(SVSS), .V_SYNC_END(SVSE), .V_TOTAL(SVT)
  ) dut_s (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (bus_s),
    .frame_start (fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (fc_s)
`endif
  );

  // Clock edges elapsed since reset was released.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Raster position is a pure function of elapsed clocks.
  function automatic logic [37:0] model_bus(input int tt, input int hv, input int hss,
                                            input int hse, input int ht, input int vv,
                                            input int vss, input int vse, input int vt);
    int h, v;
    logic [10:0] h11, v11;
    logic hs, hb, vs, vb;
    h   = tt % ht;
    v   = (tt / ht) % vt;
    h11 = 11'(h);
    v11 = 11'(v);
    hs  = (h >= hss) && (h < hse);
    hb  = (h >= hv);
    vs  = (v >= vss) && (v < vse);
    vb  = (v >= vv);
    return {v11, vs, vb, h11, hs, hb, 12'h000};
  endfunction

  function automatic logic model_fs(input int tt, input int ht, input int vt);
    return ((tt % ht) == 0) && (((tt / ht) % vt) == 0);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc bus_default", bus_d, model_bus(cyc, 800, 840, 968, 1056, 600, 601, 605, 628));
      check("cyc fs_default", fs_d, model_fs(cyc, 1056, 628));
      check("cyc bus_small", bus_s, model_bus(cyc, SHV, SHSS, SHSE, SHT, SVV, SVSS, SVSE, SVT));
      check("cyc fs_small", fs_s, model_fs(cyc, SHT, SVT));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("cyc frame_cnt_default", fc_d, 64'(16'(cyc / (1056 * 628))));
      check("cyc frame_cnt_small", fc_s, 64'(16'(cyc / (SHT * SVT))));
`endif
    end
  end

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("wait_reaches_t%0d", target), 64'(cyc >= target), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " bus_default"}, bus_d, 64'd0);
    check({tag, " fs_default"}, fs_d, 64'd1);
    check({tag, " bus_small"}, bus_s, 64'd0);
    check({tag, " fs_small"}, fs_s, 64'd1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check({tag, " frame_cnt_default"}, fc_d, 64'd0);
    check({tag, " frame_cnt_small"}, fc_s, 64'd0);
`endif
  endtask

  typedef struct {
    int t;
    bit sml;
    int h;
    int v;
    bit hs;
    bit hb;
    bit vs;
    bit vb;
    bit fs;
  } vec_t;

  vec_t tbl[$];

  task automatic run_table(input bit sml);
    logic [37:0] b;
    logic        f;
    foreach (tbl[i]) begin
      if (tbl[i].sml == sml) begin
        wait_cyc(tbl[i].t);
        b = sml ? bus_s : bus_d;
        f = sml ? fs_s : fs_d;
        check($sformatf("tbl t=%0d hcount", tbl[i].t), 64'(b[24:14]), 64'(tbl[i].h));
        check($sformatf("tbl t=%0d vcount", tbl[i].t), 64'(b[37:27]), 64'(tbl[i].v));
        check($sformatf("tbl t=%0d hsync", tbl[i].t), 64'(b[13]), 64'(tbl[i].hs));
        check($sformatf("tbl t=%0d hblnk", tbl[i].t), 64'(b[12]), 64'(tbl[i].hb));
        check($sformatf("tbl t=%0d vsync", tbl[i].t), 64'(b[26]), 64'(tbl[i].vs));
        check($sformatf("tbl t=%0d vblnk", tbl[i].t), 64'(b[25]), 64'(tbl[i].vb));
        check($sformatf("tbl t=%0d rgb", tbl[i].t), 64'(b[11:0]), 64'd0);
        check($sformatf("tbl t=%0d frame_start", tbl[i].t), 64'(f), 64'(tbl[i].fs));
      end
    end
  endtask

  initial begin
    //                t     sml  h     v   hs hb vs vb fs
    tbl.push_back('{1,     0, 1,    0,  0, 0, 0, 0, 0});
    tbl.push_back('{799,   0, 799,  0,  0, 0, 0, 0, 0});
    tbl.push_back('{800,   0, 800,  0,  0, 1, 0, 0, 0});
    tbl.push_back('{839,   0, 839,  0,  0, 1, 0, 0, 0});
    tbl.push_back('{840,   0, 840,  0,  1, 1, 0, 0, 0});
    tbl.push_back('{967,   0, 967,  0,  1, 1, 0, 0, 0});
    tbl.push_back('{968,   0, 968,  0,  0, 1, 0, 0, 0});
    tbl.push_back('{1055,  0, 1055, 0,  0, 1, 0, 0, 0});
    tbl.push_back('{1056,  0, 0,    1,  0, 0, 0, 0, 0});
    tbl.push_back('{2111,  0, 1055, 1,  0, 1, 0, 0, 0});
    tbl.push_back('{2112,  0, 0,    2,  0, 0, 0, 0, 0});
    tbl.push_back('{1,     1, 1,    0,  0, 0, 0, 0, 0});
    tbl.push_back('{234,   1, 0,    9,  0, 0, 0, 0, 0});
    tbl.push_back('{250,   1, 16,   9,  0, 1, 0, 0, 0});
    tbl.push_back('{254,   1, 20,   9,  1, 1, 0, 0, 0});
    tbl.push_back('{256,   1, 22,   9,  0, 1, 0, 0, 0});
    tbl.push_back('{259,   1, 25,   9,  0, 1, 0, 0, 0});
    tbl.push_back('{260,   1, 0,    10, 0, 0, 0, 1, 0});
    tbl.push_back('{286,   1, 0,    11, 0, 0, 1, 1, 0});
    tbl.push_back('{312,   1, 0,    12, 0, 0, 1, 1, 0});
    tbl.push_back('{338,   1, 0,    13, 0, 0, 0, 1, 0});
    tbl.push_back('{389,   1, 25,   14, 0, 1, 0, 1, 0});
    tbl.push_back('{390,   1, 0,    0,  0, 0, 0, 0, 1});
    tbl.push_back('{391,   1, 1,    0,  0, 0, 0, 0, 0});

    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_reset_values("in_reset");
    @(negedge clk);
    #1 rst = 1'b1;

    run_table(1'b0);

    // Reset asserted between edges at hcount=500 on the default instance.
    wait_cyc(2612);
    check("pre_reset hcount_default", 64'(bus_d[24:14]), 64'd500);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    run_table(1'b1);
    wait_cyc(SHT * SVT * 3 + 5);

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(200, 3000)) @(negedge clk);
      @(posedge clk);
      #($urandom_range(1, 3)) rst = 1'b0;
      #1 check_reset_values($sformatf("rand_reset%0d", k));
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #1 rst = 1'b1;
    end
    repeat (500) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
